// File: rtl/switch_mcu_exec_seq_pkg.sv
// Shared types for the execute sequencer:
// instruction class codes, FSM states, counter helper.
package switch_mcu_exec_seq_pkg;

   typedef enum logic [2:0] {
      CLS_U   = 3'd0,
      CLS_I   = 3'd1,
      CLS_R   = 3'd2,
      CLS_BR  = 3'd3,
      CLS_LD  = 3'd4,
      CLS_ST  = 3'd5,
      CLS_SYS = 3'd6
   } cls_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EXEC     = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_RETIRE   = 2'd3
   } state_e;

   localparam logic [3:0] CNT_MAX = 4'hF;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == CNT_MAX) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/switch_mcu_exec_seq_if.sv
// Decode -> sequencer instruction handshake.
// Decode is the master; the sequencer is the slave.
interface switch_mcu_exec_seq_if;

   logic       in_instr_valid;
   logic       out_instr_ready;
   logic [2:0] in_instr_class;

   modport master (
      output in_instr_valid,
      output in_instr_class,
      input  out_instr_ready
   );

   modport slave (
      input  in_instr_valid,
      input  in_instr_class,
      output out_instr_ready
   );

endinterface

// File: rtl/switch_mcu_pc_unit.sv
// Architectural PC register with override latch.
// PC advances only on the retire cycle.
module switch_mcu_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        ovr_set_i,
   input  logic [31:0] ovr_pc_i,
   input  logic        advance_i,
   output logic [31:0] pc_o
);

   logic        ovr_q, ovr_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] pc_q, pc_d;

   // next-PC mux; a later override overwrites an earlier one
   always_comb begin
      ovr_d = ovr_q;
      tgt_d = tgt_q;
      pc_d  = pc_q;
      if (advance_i) begin
         pc_d  = ovr_q ? tgt_q : pc_q + 32'd4;
         ovr_d = 1'b0;
      end else if (ovr_set_i) begin
         ovr_d = 1'b1;
         tgt_d = ovr_pc_i & 32'hFFFF_FFFC;
      end
   end

   // PC and override latch registers
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         ovr_q <= 1'b0;
         tgt_q <= 32'h0;
         pc_q  <= RESET_PC;
      end else begin
         ovr_q <= ovr_d;
         tgt_q <= tgt_d;
         pc_q  <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/switch_mcu_exec_seq.sv
// Execute sequencer: one instruction at a time,
// drives the ex-unit cycle counter and retires.
module switch_mcu_exec_seq
   import switch_mcu_exec_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ALU_CYCLES  = 3,
   parameter int          MEM_TIMEOUT = 15
) (
   input  logic                        in_clk,
   input  logic                        in_rst,
   switch_mcu_exec_seq_if.slave        dec,
   input  logic                        in_pc_override,
   input  logic [31:0]                 in_pc_write,
   input  logic                        in_mem_done,
   output logic [3:0]                  out_cycle_cnt,
   output logic [31:0]                 out_pc_reg,
   output logic                        out_ex_active,
   output logic                        out_retire,
   output logic                        out_timeout_err
);

   localparam logic [3:0] ALU_LAST = 4'(ALU_CYCLES - 1);
   localparam logic [3:0] TMO_CNT  = 4'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] cls_q, cls_d;
   logic       err_q, err_d;
   logic       retire_q, retire_d;

   // next state, counter, class latch and sticky error
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cls_d   = cls_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (dec.in_instr_valid) begin
               cls_d   = dec.in_instr_class;
               cnt_d   = 4'd0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            cnt_d = sat_inc(cnt_q);
            case (cls_q)
               CLS_U, CLS_I, CLS_R, CLS_BR: begin
                  if (cnt_q == ALU_LAST) state_d = ST_RETIRE;
               end
               CLS_LD, CLS_ST: begin
                  if (cnt_q == 4'd1) state_d = ST_MEM_WAIT;
               end
               default: state_d = ST_RETIRE;
            endcase
         end
         ST_MEM_WAIT: begin
            cnt_d = sat_inc(cnt_q);
            if (in_mem_done) begin
               state_d = ST_RETIRE;
            end else if (cnt_q == TMO_CNT) begin
               err_d   = 1'b1;
               state_d = ST_RETIRE;
            end
         end
         ST_RETIRE: begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      retire_d = (state_d == ST_RETIRE);
   end

   // FSM and datapath registers
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         cls_q    <= 3'd0;
         err_q    <= 1'b0;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cls_q    <= cls_d;
         err_q    <= err_d;
         retire_q <= retire_d;
      end
   end

   switch_mcu_pc_unit #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .in_clk    (in_clk),
      .in_rst    (in_rst),
      .ovr_set_i (in_pc_override && state_q == ST_EXEC),
      .ovr_pc_i  (in_pc_write),
      .advance_i (state_q == ST_RETIRE),
      .pc_o      (out_pc_reg)
   );

   assign dec.out_instr_ready = (state_q == ST_IDLE);
   assign out_ex_active       = (state_q == ST_EXEC) ||
                                (state_q == ST_MEM_WAIT);
   assign out_cycle_cnt       = cnt_q;
   assign out_retire          = retire_q;
   assign out_timeout_err     = err_q;

endmodule

// File: tb/tb_switch_mcu_exec_seq.sv
// Directed bench for the execute sequencer.
// Drives and samples on the falling edge.
module tb_switch_mcu_exec_seq;
   import switch_mcu_exec_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ovr = 1'b0;
   logic [31:0] pcw = 32'h0;
   logic        done = 1'b0;
   logic [3:0]  cnt;
   logic [31:0] pc;
   logic        exa, ret, err;
   int          n_chk = 0;
   int          n_fail = 0;

   switch_mcu_exec_seq_if dif();

   always #5 clk = ~clk;

   switch_mcu_exec_seq #(
      .RESET_PC    (32'h0000_0000),
      .ALU_CYCLES  (3),
      .MEM_TIMEOUT (15)
   ) dut (
      .in_clk          (clk),
      .in_rst          (rst_n),
      .dec             (dif.slave),
      .in_pc_override  (ovr),
      .in_pc_write     (pcw),
      .in_mem_done     (done),
      .out_cycle_cnt   (cnt),
      .out_pc_reg      (pc),
      .out_ex_active   (exa),
      .out_retire      (ret),
      .out_timeout_err (err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic accept(input logic [2:0] cls);
      chk("ready_idle", 32'(dif.out_instr_ready), 1);
      dif.in_instr_valid = 1'b1;
      dif.in_instr_class = cls;
      @(negedge clk);
      dif.in_instr_valid = 1'b0;
      chk("exa_first", 32'(exa), 1);
      chk("cnt_first", 32'(cnt), 0);
   endtask

   task automatic wait_cnt(input string tag, input logic [3:0] v);
      int g = 0;
      while (cnt != v && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk(tag, 32'(cnt), 32'(v));
   endtask

   task automatic run_to_retire(input string tag, input int exp_n,
                                input logic [31:0] exp_pc);
      int n = 0;
      while (!ret && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, exp_n);
      chk({tag, "_ret"}, 32'(ret), 1);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(ret), 0);
      chk({tag, "_rdy"}, 32'(dif.out_instr_ready), 1);
      chk({tag, "_pc"}, pc, exp_pc);
   endtask

   initial begin
      int bad;
      dif.in_instr_valid = 1'b0;
      dif.in_instr_class = 3'd0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(dif.out_instr_ready), 1);
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_ret", 32'(ret), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_exa", 32'(exa), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // BR, single override at cnt 1, low bits dropped
      accept(CLS_BR);
      @(negedge clk);
      chk("br_cnt1", 32'(cnt), 1);
      ovr = 1'b1;
      pcw = 32'h0000_0203;
      @(negedge clk);
      ovr = 1'b0;
      pcw = 32'h0;
      run_to_retire("br", 1, 32'h0000_0200);

      // BR, two overrides: last one wins
      accept(CLS_BR);
      ovr = 1'b1;
      pcw = 32'h0000_0500;
      @(negedge clk);
      ovr = 1'b0;
      @(negedge clk);
      ovr = 1'b1;
      pcw = 32'h0000_0100;
      @(negedge clk);
      ovr = 1'b0;
      pcw = 32'h0;
      run_to_retire("brlast", 0, 32'h0000_0100);

      // I-type; a valid pulse during EXEC must be ignored
      accept(CLS_I);
      @(negedge clk);
      chk("i_cnt1", 32'(cnt), 1);
      chk("i_busy", 32'(dif.out_instr_ready), 0);
      dif.in_instr_valid = 1'b1;
      dif.in_instr_class = CLS_SYS;
      @(negedge clk);
      dif.in_instr_valid = 1'b0;
      chk("i_cnt2", 32'(cnt), 2);
      chk("i_pc_hold", pc, 32'h0000_0100);
      run_to_retire("i", 1, 32'h0000_0104);

      // LD, stray done in EXEC ignored, done at cnt 5
      accept(CLS_LD);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      wait_cnt("ld_cnt5", 4'd5);
      chk("ld_exa", 32'(exa), 1);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      run_to_retire("ld", 0, 32'h0000_0108);
      chk("ld_err", 32'(err), 0);

      // LD, done coincides with timeout: done wins
      accept(CLS_LD);
      wait_cnt("ld15_cnt", 4'd15);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      run_to_retire("ld15", 0, 32'h0000_010C);
      chk("ld15_err", 32'(err), 0);

      // ST, no done: timeout after cnt 15
      accept(CLS_ST);
      run_to_retire("st", 16, 32'h0000_0110);
      chk("st_err", 32'(err), 1);

      // SYS retires after one EXEC cycle; error stays sticky
      accept(CLS_SYS);
      run_to_retire("sys", 1, 32'h0000_0114);
      chk("sys_err", 32'(err), 1);

      // PC wrap
      accept(CLS_BR);
      ovr = 1'b1;
      pcw = 32'hFFFF_FFFF;
      @(negedge clk);
      ovr = 1'b0;
      pcw = 32'h0;
      run_to_retire("brw", 2, 32'hFFFF_FFFC);
      accept(CLS_R);
      run_to_retire("wrap", 3, 32'h0000_0000);

      // async reset during MEM_WAIT
      accept(CLS_LD);
      wait_cnt("mr_cnt4", 4'd4);
      rst_n = 1'b0;
      #1;
      chk("mr_ready", 32'(dif.out_instr_ready), 1);
      chk("mr_exa", 32'(exa), 0);
      chk("mr_cnt", 32'(cnt), 0);
      chk("mr_pc", pc, 32'h0);
      chk("mr_ret", 32'(ret), 0);
      chk("mr_err", 32'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ret || !dif.out_instr_ready) bad++;
      end
      chk("mr_quiet", bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
